// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: alignment mode encodings and
// the channel-index width helper.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Channel-select width; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, compare against the shared counter,
// and a registered output.
module pwm_channel #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             duty_wr,
    input  logic [CNT_W-1:0] duty,
    input  logic             update,
    input  logic             period_nz,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);

    logic [CNT_W-1:0] shadow_duty;
    logic [CNT_W-1:0] active_duty;
    logic [CNT_W-1:0] next_duty;
    logic [CNT_W-1:0] cmp_duty;

    // A write landing on the update cycle goes straight into the compare.
    assign next_duty = duty_wr ? duty : shadow_duty;
    assign cmp_duty  = update ? next_duty : active_duty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_duty <= '0;
            active_duty <= '0;
            pwm         <= 1'b0;
        end else begin
            if (duty_wr) shadow_duty <= duty;
            if (update)  active_duty <= next_duty;
            pwm <= i_en && period_nz && (cnt < cmp_duty);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared up or up/down counter, runtime
// period/mode/duty loaded from shadow registers at each period boundary.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter  int CH_NUM = 4,
    parameter  int CNT_W  = 8,
    localparam int IDX_W  = ch_idx_w(CH_NUM)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_period_wr,
    input  logic [CNT_W-1:0]  i_period,
    input  logic              i_mode,
    input  logic              i_duty_wr,
    input  logic [IDX_W-1:0]  i_duty_ch,
    input  logic [CNT_W-1:0]  i_duty,
    output logic [CH_NUM-1:0] o_pwm,
    output logic              o_cycle_start,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [CNT_W-1:0] cnt;
    logic             dir_up;
    logic [CNT_W-1:0] sh_period;
    logic             sh_mode;
    logic [CNT_W-1:0] act_period;
    logic             act_mode;
    logic             cycle_start;

    logic             update;
    logic [CNT_W-1:0] eff_period;
    logic             eff_mode;
    logic             eff_dir;
    logic             center;
    logic             at_top;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir_nxt;

    // Strobes are single-cycle writes with no back-pressure: every asserted
    // i_period_wr / i_duty_wr cycle is taken, a later write overwrites.
    assign update     = i_en && (cnt == '0);
    assign eff_period = update ? (i_period_wr ? i_period : sh_period) : act_period;
    assign eff_mode   = update ? (i_period_wr ? i_mode : sh_mode) : act_mode;
    assign eff_dir    = update || dir_up;
    assign center     = (eff_mode == MODE_CENTER) && (eff_period > CNT_W'(1));
    assign at_top     = (cnt >= eff_period - CNT_W'(1));

    always_comb begin
        cnt_nxt = '0;
        dir_nxt = 1'b1;
        if (i_en && (eff_period > CNT_W'(1))) begin
            if (!center) begin
                cnt_nxt = at_top ? '0 : cnt + CNT_W'(1);
            end else if (eff_dir && !at_top) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                // Turn around at the top; return to up once the count hits 0.
                cnt_nxt = cnt - CNT_W'(1);
                dir_nxt = (cnt <= CNT_W'(1));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt         <= '0;
            dir_up      <= 1'b1;
            sh_period   <= '0;
            sh_mode     <= MODE_EDGE;
            act_period  <= '0;
            act_mode    <= MODE_EDGE;
            cycle_start <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            dir_up <= dir_nxt;
            if (i_period_wr) begin
                sh_period <= i_period;
                sh_mode   <= i_mode;
            end
            if (update) begin
                act_period <= eff_period;
                act_mode   <= eff_mode;
            end
            cycle_start <= update && (eff_period != '0);
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en),
            .duty_wr   (i_duty_wr && (i_duty_ch == IDX_W'(c))),
            .duty      (i_duty),
            .update    (update),
            .period_nz (eff_period != '0),
            .cnt       (cnt),
            .pwm       (o_pwm[c])
        );
    end

    assign o_cycle_start = cycle_start;
    assign o_cnt         = cnt;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: table of period/duty vectors, hand-written corner
// sequences, and randomized traffic against a period-position reference model.
module tb_pwm_multi;

    localparam int CH_NUM = 4;
    localparam int CNT_W  = 8;

    logic              i_clk;
    logic              i_rst;
    logic              i_en;
    logic              i_period_wr;
    logic [CNT_W-1:0]  i_period;
    logic              i_mode;
    logic              i_duty_wr;
    logic [1:0]        i_duty_ch;
    logic [CNT_W-1:0]  i_duty;
    logic [CH_NUM-1:0] o_pwm;
    logic              o_cycle_start;
    logic [CNT_W-1:0]  o_cnt;

    int checks = 0;
    int errors = 0;

    pwm_multi #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_period_wr   (i_period_wr),
        .i_period      (i_period),
        .i_mode        (i_mode),
        .i_duty_wr     (i_duty_wr),
        .i_duty_ch     (i_duty_ch),
        .i_duty        (i_duty),
        .o_pwm         (o_pwm),
        .o_cycle_start (o_cycle_start),
        .o_cnt         (o_cnt)
    );

    // clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // reference model: position k inside the current period
    int          m_k;
    int          m_sh_p, m_act_p;
    logic        m_sh_m, m_act_m;
    int          m_sh_d[CH_NUM];
    int          m_act_d[CH_NUM];
    logic [CH_NUM-1:0] m_pwm;
    logic        m_cs;
    int          m_cnt;

    function automatic int per_len();
        if (m_act_p == 0) return 1;
        if (m_act_m && m_act_p > 1) return 2 * m_act_p - 2;
        return m_act_p;
    endfunction

    function automatic int cnt_of(input int k);
        if (m_act_m && m_act_p > 1 && k >= m_act_p) return 2 * m_act_p - 2 - k;
        return k;
    endfunction

    task automatic model_update();
        int c;
        if (i_rst) begin
            m_k = 0; m_sh_p = 0; m_act_p = 0; m_sh_m = 0; m_act_m = 0;
            for (int i = 0; i < CH_NUM; i++) begin
                m_sh_d[i] = 0;
                m_act_d[i] = 0;
            end
            m_pwm = '0; m_cs = 0; m_cnt = 0;
        end else begin
            if (i_period_wr) begin
                m_sh_p = int'(i_period);
                m_sh_m = i_mode;
            end
            if (i_duty_wr && int'(i_duty_ch) < CH_NUM) m_sh_d[i_duty_ch] = int'(i_duty);
            if (!i_en) begin
                m_k = 0; m_pwm = '0; m_cs = 0;
            end else begin
                if (m_k == 0) begin
                    m_act_p = m_sh_p;
                    m_act_m = m_sh_m;
                    for (int i = 0; i < CH_NUM; i++) m_act_d[i] = m_sh_d[i];
                end
                c = cnt_of(m_k);
                for (int i = 0; i < CH_NUM; i++) m_pwm[i] = (m_act_p != 0) && (c < m_act_d[i]);
                m_cs = (m_k == 0) && (m_act_p >= 1);
                m_k = (m_k + 1) % per_len();
            end
            m_cnt = cnt_of(m_k);
        end
    endtask

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge i_clk);
        model_update();
        #1;
        check("model_pwm", 32'(o_pwm), 32'(m_pwm));
        check("model_cs", 32'(o_cycle_start), 32'(m_cs));
        check("model_cnt", 32'(o_cnt), 32'(m_cnt));
    endtask

    task automatic clear_strobes();
        i_period_wr = 0; i_duty_wr = 0;
    endtask

    task automatic do_reset();
        clear_strobes();
        i_en = 0; i_rst = 1;
        step();
        i_rst = 0;
    endtask

    task automatic cfg_period(input int p, input logic m);
        i_period_wr = 1; i_period = CNT_W'(p); i_mode = m;
        step();
        clear_strobes();
    endtask

    task automatic cfg_duty(input int ch, input int d);
        i_duty_wr = 1; i_duty_ch = 2'(ch); i_duty = CNT_W'(d);
        step();
        clear_strobes();
    endtask

    typedef struct {
        int   period;
        logic mode;
        int   ch;
        int   duty;
        int   exp_high;
        int   exp_starts;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int h, s;
        vecs[0] = '{8, 1'b0, 0, 3,   6,  2};
        vecs[1] = '{5, 1'b1, 1, 2,   6,  2};
        vecs[2] = '{8, 1'b0, 2, 0,   0,  2};
        vecs[3] = '{8, 1'b0, 0, 8,   16, 2};
        vecs[4] = '{8, 1'b0, 3, 255, 16, 2};
        vecs[5] = '{0, 1'b0, 0, 5,   0,  0};
        vecs[6] = '{1, 1'b0, 1, 1,   16, 16};
        vecs[7] = '{1, 1'b1, 2, 0,   0,  16};
        vecs[8] = '{5, 1'b1, 0, 5,   16, 2};
        vecs[9] = '{6, 1'b0, 3, 1,   3,  3};

        i_rst = 1; i_en = 0; i_period = 0; i_mode = 0;
        i_duty_ch = 0; i_duty = 0; clear_strobes();
        do_reset();
        check("reset_pwm", 32'(o_pwm), 0);
        check("reset_cs", 32'(o_cycle_start), 0);
        check("reset_cnt", 32'(o_cnt), 0);

        // table-driven: high cycles and period starts over 16 cycles
        for (int v = 0; v < 10; v++) begin
            do_reset();
            cfg_period(vecs[v].period, vecs[v].mode);
            cfg_duty(vecs[v].ch, vecs[v].duty);
            i_en = 1;
            h = 0; s = 0;
            for (int t = 0; t < 16; t++) begin
                step();
                h += int'(o_pwm[vecs[v].ch]);
                s += int'(o_cycle_start);
            end
            check($sformatf("vec%0d_high", v), 32'(h), 32'(vecs[v].exp_high));
            check($sformatf("vec%0d_starts", v), 32'(s), 32'(vecs[v].exp_starts));
            i_en = 0;
        end

        // mid-period duty write keeps current period, applies next
        do_reset();
        cfg_period(8, 1'b0);
        cfg_duty(0, 3);
        i_en = 1; h = 0;
        repeat (4) begin step(); h += int'(o_pwm[0]); end
        check("mid_cnt", 32'(o_cnt), 4);
        i_duty_wr = 1; i_duty_ch = 0; i_duty = 6;
        step(); h += int'(o_pwm[0]);
        clear_strobes();
        repeat (3) begin step(); h += int'(o_pwm[0]); end
        check("mid_old_high", 32'(h), 3);
        h = 0;
        repeat (8) begin step(); h += int'(o_pwm[0]); end
        check("mid_new_high", 32'(h), 6);

        // write on the update cycle takes effect immediately
        check("upd_cnt0", 32'(o_cnt), 0);
        i_duty_wr = 1; i_duty_ch = 0; i_duty = 5; h = 0;
        step(); h += int'(o_pwm[0]);
        clear_strobes();
        repeat (7) begin step(); h += int'(o_pwm[0]); end
        check("upd_bypass_high", 32'(h), 5);

        // enable low mid-period
        repeat (3) step();
        i_en = 0;
        step();
        check("en_low_pwm", 32'(o_pwm), 0);
        check("en_low_cnt", 32'(o_cnt), 0);
        check("en_low_cs", 32'(o_cycle_start), 0);

        // reset mid-period drops shadow values
        i_en = 1;
        repeat (3) step();
        i_rst = 1;
        step();
        check("rst_mid_pwm", 32'(o_pwm), 0);
        check("rst_mid_cnt", 32'(o_cnt), 0);
        i_rst = 0;
        h = 0; s = 0;
        repeat (8) begin step(); h += int'(o_pwm != 0); s += int'(o_cycle_start); end
        check("post_rst_high", 32'(h), 0);
        check("post_rst_starts", 32'(s), 0);

        // randomized traffic against the reference model
        do_reset();
        i_en = 1;
        for (int n = 0; n < 4000; n++) begin
            i_period_wr = ($urandom_range(0, 39) == 0);
            i_period    = CNT_W'($urandom_range(0, 12));
            i_mode      = 1'($urandom_range(0, 1));
            i_duty_wr   = ($urandom_range(0, 7) == 0);
            i_duty_ch   = 2'($urandom_range(0, 3));
            i_duty      = CNT_W'($urandom_range(0, 14));
            if ($urandom_range(0, 99) == 0) i_en = ~i_en;
            i_rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        i_rst = 0;
        clear_strobes();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
